// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep checker: FSM states,
// gate result bit positions and the mismatch popcount helper.
package gate_sweep_pkg;

    localparam int GATE_W   = 7;
    localparam int NUM_VEC  = 4;

    localparam int AND_IDX  = 6;
    localparam int OR_IDX   = 5;
    localparam int NAND_IDX = 4;
    localparam int NOR_IDX  = 3;
    localparam int XOR_IDX  = 2;
    localparam int XNOR_IDX = 1;
    localparam int NOT_IDX  = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Number of set bits in a gate result vector (0..7).
    function automatic logic [2:0] popcount_gate(input logic [GATE_W-1:0] v);
        logic [2:0] cnt;
        cnt = '0;
        for (int i = 0; i < GATE_W; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Bus between the sweep checker and its environment: sweep control,
// gate stimulus/results and the result summary.
interface gate_sweep_checker_if
    import gate_sweep_pkg::*;
#(
    parameter int CNT_W = 8
) ();

    logic              start;
    logic              a;
    logic              b;
    logic [GATE_W-1:0] gate_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_cnt;
    logic [3:0]        fail_vec;

    // master: the checker itself; slave: whoever requests sweeps and hosts the gates
    modport master (
        input  start, gate_out,
        output a, b, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        output start, gate_out,
        input  a, b, busy, done, pass, err_cnt, fail_vec
    );

endinterface

// File: rtl/gate_sweep_checker_expect.sv
// Golden model of the gate block: the seven gate results for one {a,b} pair.
module gate_expect
    import gate_sweep_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [GATE_W-1:0] expected
);

    always_comb begin
        expected           = '0;
        expected[AND_IDX]  = a & b;
        expected[OR_IDX]   = a | b;
        expected[NAND_IDX] = ~(a & b);
        expected[NOR_IDX]  = ~(a | b);
        expected[XOR_IDX]  = a ^ b;
        expected[XNOR_IDX] = ~(a ^ b);
        expected[NOT_IDX]  = ~a;
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps {a,b} through 00,01,10,11, lets each vector settle, then scores the
// gate block against the golden model. Optional GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first bad vector.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_sweep_checker_if.master bus
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam int SUM_W = CNT_W + 3;
    localparam logic [SUM_W-1:0] ERR_MAX = {3'b000, {CNT_W{1'b1}}};

    state_t             r_state;
    logic [1:0]         r_vec;
    logic [HOLD_W-1:0]  r_hold;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [3:0]         r_fail_vec;

    state_t             w_state_next;
    logic [1:0]         w_vec_next;
    logic [HOLD_W-1:0]  w_hold_next;
    logic [CNT_W-1:0]   w_err_next;
    logic [3:0]         w_fail_next;

    logic               w_busy;
    logic [GATE_W-1:0]  w_expected;
    logic [GATE_W-1:0]  w_mismatch;
    logic [2:0]         w_pop;
    logic [SUM_W-1:0]   w_err_sum;
    logic [CNT_W-1:0]   w_err_sat;
    logic               w_last_vec;
    logic               w_stop;

    gate_expect u_expect (
        .a        (r_vec[1]),
        .b        (r_vec[0]),
        .expected (w_expected)
    );

    assign w_mismatch = bus.gate_out ^ w_expected;
    assign w_pop      = popcount_gate(w_mismatch);
    assign w_err_sum  = {3'b000, r_err_cnt} + {{(SUM_W-3){1'b0}}, w_pop};
    assign w_err_sat  = (w_err_sum > ERR_MAX) ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];
    assign w_last_vec = (r_vec == 2'd3);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    assign w_stop = w_last_vec || (w_mismatch != '0);
`else
    assign w_stop = w_last_vec;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_vec      <= '0;
            r_hold     <= '0;
            r_err_cnt  <= '0;
            r_fail_vec <= '0;
        end else begin
            r_state    <= w_state_next;
            r_vec      <= w_vec_next;
            r_hold     <= w_hold_next;
            r_err_cnt  <= w_err_next;
            r_fail_vec <= w_fail_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_vec_next   = r_vec;
        w_hold_next  = r_hold;
        w_err_next   = r_err_cnt;
        w_fail_next  = r_fail_vec;
        unique case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_next = DRIVE;
                    w_vec_next   = '0;
                    w_hold_next  = '0;
                    w_err_next   = '0;
                    w_fail_next  = '0;
                end
            end
            DRIVE: begin
                if (r_hold == HOLD_LAST) begin
                    w_hold_next  = '0;
                    w_state_next = SAMPLE;
                end else begin
                    w_hold_next  = r_hold + 1'b1;
                end
            end
            SAMPLE: begin
                w_err_next = w_err_sat;
                if (w_mismatch != '0) begin
                    w_fail_next[r_vec] = 1'b1;
                end
                if (w_stop) begin
                    w_state_next = DONE;
                end else begin
                    w_vec_next   = r_vec + 2'd1;
                    w_state_next = DRIVE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outside a sweep the gate inputs park at 00 so the gate block sees a known vector.
    assign w_busy       = (r_state == DRIVE) || (r_state == SAMPLE);
    assign bus.busy     = w_busy;
    assign bus.a        = w_busy & r_vec[1];
    assign bus.b        = w_busy & r_vec[0];
    assign bus.done     = (r_state == DONE);
    assign bus.pass     = (r_state == DONE) && (r_err_cnt == '0);
    assign bus.err_cnt  = r_err_cnt;
    assign bus.fail_vec = r_fail_vec;

endmodule
